// File: rtl/seq_blk_pkg.sv
// +--------------------------------------------------------------+
// | seq_blk_pkg : shared constants for the seq_blk_det slice      |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

package seq_blk_pkg;
  localparam logic MODE_OVERLAP = 1'b0;
  localparam logic MODE_NONOVL  = 1'b1;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_DLY   = 3;
endpackage

`default_nettype wire

// File: rtl/seq_blk_dline.sv
// +--------------------------------------------------------------+
// | seq_blk_dline : DLY-stage synchronous-reset bit delay line    |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module seq_blk_dline
  import seq_blk_pkg::*;
#(
  parameter int DLY = DEF_DLY
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DLY-1:0] r_stage;

  generate
    if (DLY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) r_stage <= '0;
        else     r_stage <= d;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) r_stage <= '0;
        else     r_stage <= {r_stage[DLY-2:0], d};
      end
    end
  endgenerate

  assign q = r_stage[DLY-1];

endmodule

`default_nettype wire

// File: rtl/seq_blk_det.sv
// +--------------------------------------------------------------+
// | seq_blk_det : serial pattern detector, saturating match       |
// | counter, rise detector and delay line. SEQ_BLK_STICKY_EN      |
// | adds clr / out_sticky.                  Rev 1.0               |
// +--------------------------------------------------------------+
`default_nettype none

module seq_blk_det
  import seq_blk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DLY   = DEF_DLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in,
  input  logic [WIDTH-1:0] pat,
  input  logic             mode,
  output logic             out_dly,
  output logic             out_match,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_rise
`ifdef SEQ_BLK_STICKY_EN
  ,
  input  logic             clr,
  output logic             out_sticky
`endif
);

  localparam int                c_fill_w    = $clog2(WIDTH + 1);
  localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(WIDTH);
  localparam logic [c_fill_w-1:0] c_fill_last = c_fill_w'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

  logic [WIDTH-2:0]    r_sr;
  logic [c_fill_w-1:0] r_fill;
  logic                r_prev;
  logic                r_match;
  logic                r_rise;
  logic [CNT_W-1:0]    r_cnt;

  logic [WIDTH-1:0]    w_win;
  logic                w_match;

  // Window includes the bit being accepted this cycle, so the match is seen on the completing edge.
  assign w_win   = {r_sr, in};
  assign w_match = in_vld && (r_fill >= c_fill_last) && (w_win == pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= '0;
      r_fill  <= '0;
      r_prev  <= 1'b0;
      r_match <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_match <= w_match;
      r_rise  <= in_vld & in & ~r_prev;
      if (in_vld) begin
        r_sr   <= w_win[WIDTH-2:0];
        r_prev <= in;
        if (w_match && (mode == MODE_NONOVL))
          r_fill <= '0;
        else if (r_fill != c_fill_full)
          r_fill <= r_fill + 1'b1;
      end
      if (w_match && (r_cnt != c_cnt_max))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  seq_blk_dline #(
    .DLY (DLY)
  ) u_dline (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (out_dly)
  );

  assign out_match = r_match;
  assign out_cnt   = r_cnt;
  assign out_rise  = r_rise;

`ifdef SEQ_BLK_STICKY_EN
  logic r_sticky;

  // Set has priority over clear when both land on the same edge.
  always_ff @(posedge clk) begin
    if (rst)          r_sticky <= 1'b0;
    else if (w_match) r_sticky <= 1'b1;
    else if (clr)     r_sticky <= 1'b0;
  end

  assign out_sticky = r_sticky;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_blk_det.sv
// +--------------------------------------------------------------+
// | tb_seq_blk_det : self-checking bench for seq_blk_det          |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module tb_seq_blk_det;

  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int CW2 = 2;
  localparam int D   = 3;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic          din;
  logic [W-1:0]  pat;
  logic          mode;
  logic          clr;

  logic          out_dly, out_match, out_rise;
  logic [CW-1:0] out_cnt;
  logic          out_dly2, out_match2, out_rise2;
  logic [CW2-1:0] out_cnt2;
`ifdef SEQ_BLK_STICKY_EN
  logic          out_sticky, out_sticky2;
`endif

  seq_blk_det #(.WIDTH(W), .CNT_W(CW), .DLY(D)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in(din), .pat(pat), .mode(mode),
    .out_dly(out_dly), .out_match(out_match), .out_cnt(out_cnt), .out_rise(out_rise)
`ifdef SEQ_BLK_STICKY_EN
    , .clr(clr), .out_sticky(out_sticky)
`endif
  );

  seq_blk_det #(.WIDTH(W), .CNT_W(CW2), .DLY(D)) dut2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in(din), .pat(pat), .mode(mode),
    .out_dly(out_dly2), .out_match(out_match2), .out_cnt(out_cnt2), .out_rise(out_rise2)
`ifdef SEQ_BLK_STICKY_EN
    , .clr(clr), .out_sticky(out_sticky2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of accepted bits and count since the last clear.
  bit   hist[$];
  bit   dq[$];
  int   since;
  int   exp_cnt, exp_cnt2;
  bit   prev, exp_match, exp_rise, exp_dly;
  bit   chk_en = 1'b0;
`ifdef SEQ_BLK_STICKY_EN
  bit   exp_sticky;
`endif

  always @(posedge clk) begin
    bit m;
    if (rst) begin
      hist.delete();
      dq.delete();
      for (int i = 0; i < D; i++) dq.push_back(1'b0);
      since = 0; exp_cnt = 0; exp_cnt2 = 0; prev = 0;
      exp_match = 0; exp_rise = 0; exp_dly = 0;
`ifdef SEQ_BLK_STICKY_EN
      exp_sticky = 0;
`endif
      chk_en = 1'b1;
    end else begin
      dq.push_back(din);
      void'(dq.pop_front());
      exp_dly = dq[0];
      m = 0;
      exp_rise = 0;
      if (in_vld) begin
        hist.push_back(din);
        if (hist.size() > W) void'(hist.pop_front());
        if (since < W) since++;
        if (since >= W) begin
          m = 1;
          for (int i = 0; i < W; i++)
            if (hist[hist.size()-1-i] != pat[i]) m = 0;
        end
        exp_rise = din && !prev;
        prev = din;
        if (m) begin
          if (exp_cnt  < (1 << CW)  - 1) exp_cnt++;
          if (exp_cnt2 < (1 << CW2) - 1) exp_cnt2++;
          if (mode) since = 0;
        end
      end
      exp_match = m;
`ifdef SEQ_BLK_STICKY_EN
      if (m) exp_sticky = 1;
      else if (clr) exp_sticky = 0;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("match",  {31'd0, out_match},  {31'd0, exp_match});
      check("rise",   {31'd0, out_rise},   {31'd0, exp_rise});
      check("dly",    {31'd0, out_dly},    {31'd0, exp_dly});
      check("cnt",    32'(out_cnt),        32'(exp_cnt));
      check("cnt2",   32'(out_cnt2),       32'(exp_cnt2));
      check("match2", {31'd0, out_match2}, {31'd0, exp_match});
`ifdef SEQ_BLK_STICKY_EN
      check("sticky", {31'd0, out_sticky}, {31'd0, exp_sticky});
`endif
    end
  end

  int n_match, n_match2, n_rise;
  always @(negedge clk) begin
    if (out_match  === 1'b1) n_match++;
    if (out_match2 === 1'b1) n_match2++;
    if (out_rise   === 1'b1) n_rise++;
  end

  task automatic drive(input bit v, input bit d, input bit r = 1'b0, input bit c = 1'b0);
    @(negedge clk);
    #1;
    in_vld = v; din = d; rst = r; clr = c;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1);
    n_match = 0; n_match2 = 0; n_rise = 0;
  endtask

  task automatic feed(input bit [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i]);
  endtask

  initial begin
    bit obs[20];
    int hi, side;
    rst = 1'b1; in_vld = 1'b0; din = 1'b0; pat = 4'b1011; mode = 1'b0; clr = 1'b0;

    // 1: overlapping 1011 in 1011011
    do_reset();
    check("t1_reset_cnt", 32'(out_cnt), 32'd0);
    feed(16'b1011011, 7);
    drive(1'b0, 1'b0);
    check("t1_pulses", 32'(n_match), 32'd2);
    check("t1_cnt", 32'(out_cnt), 32'd2);
    check("t1_model_cnt", 32'(exp_cnt), 32'd2);

    // 2: non-overlapping
    mode = 1'b1;
    do_reset();
    feed(16'b1011011, 7);
    drive(1'b0, 1'b0);
    check("t2_pulses", 32'(n_match), 32'd1);
    check("t2_cnt", 32'(out_cnt), 32'd1);

    // 3: saturation of the 2-bit counter
    mode = 1'b0; pat = 4'b1111;
    do_reset();
    feed(16'b1111111111, 10);
    drive(1'b0, 1'b0);
    check("t3_pulses2", 32'(n_match2), 32'd7);
    check("t3_cnt2", 32'(out_cnt2), 32'd3);
    check("t3_cnt", 32'(out_cnt), 32'd7);

    // 4: reset mid-stream discards partial pattern
    pat = 4'b1011;
    do_reset();
    feed(16'b101, 3);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1);
    check("t4_post_rst_match", {31'd0, out_match}, 32'd0);
    check("t4_post_rst_cnt", 32'(out_cnt), 32'd0);
    check("t4_post_rst_rise", {31'd0, out_rise}, 32'd0);
    check("t4_post_rst_dly", {31'd0, out_dly}, 32'd0);
    drive(1'b0, 1'b0);
    check("t4_cnt", 32'(out_cnt), 32'd0);
    check("t4_pulses", 32'(n_match), 32'd0);

    // 5: delay line independent of in_vld
    do_reset();
    hi = 0; side = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, k == 10);
      obs[k] = out_dly;
      hi += int'(out_dly);
      side += int'(out_match) + int'(out_rise) + int'(out_cnt);
    end
    check("t5_dly_at13", {31'd0, obs[13]}, 32'd1);
    check("t5_dly_count", 32'(hi), 32'd1);
    check("t5_side", 32'(side), 32'd0);

    // 6: rise detection with idle cycles between accepts
    do_reset();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check("t6_rises", 32'(n_rise), 32'd1);

`ifdef SEQ_BLK_STICKY_EN
    do_reset();
    feed(16'b101, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_sticky_set", {31'd0, out_sticky}, 32'd1);
    drive(1'b0, 1'b0);
    check("t6_sticky_clr", {31'd0, out_sticky}, 32'd0);
`endif

    // Long run of ones saturates the 8-bit counter
    pat = 4'b1111; mode = 1'b0;
    do_reset();
    for (int k = 0; k < 300; k++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    check("sat_cnt", 32'(out_cnt), 32'd255);

    // Randomized traffic with occasional pattern/mode changes, resets and clears
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) pat  = W'($urandom);
      if ($urandom_range(0, 79) == 0) mode = ~mode;
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0);
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_blk_det.md
Name: seq_blk_det

Overview:
Parametrised successor to the fixed three-output sequential block. It is a bit-serial sequence unit with four functions:
- programmable-pattern detector (overlap or non-overlap mode)
- saturating match counter
- valid-qualified rising-edge detector
- fixed-depth delay line

It sits at the front of serial-input datapaths as a reusable DC/synthesis exercise block with synchronous-reset flops only.

Parameters:
WIDTH, 4, pattern length in bits (>=2)
CNT_W, 8, match counter width (>=1)
DLY, 3, delay-line depth in cycles (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_vld  in  1  qualifies in for pattern/edge logic
in  in  1  serial data bit
pat  in  WIDTH  target pattern; pat[WIDTH-1] = oldest bit
mode  in  1  0 = overlapping, 1 = non-overlapping
out_dly  out  1  in delayed DLY cycles
out_match  out  1  one-cycle match pulse
out_cnt  out  CNT_W  saturating match count
out_rise  out  1  one-cycle pulse on valid 0->1 transition

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. On a rst edge, all state clears: sr, fill, prev bit, delay line, out_dly, out_match, out_cnt, out_rise all go to 0. rst has priority over every other input.
- Accept: an edge with in_vld=1. On accept:
  - sr <= {sr[WIDTH-2:0], in}
  - fill increments, saturating at WIDTH
- Match condition: accept AND (fill == WIDTH-1 or WIDTH) AND {sr[WIDTH-2:0], in} == pat. It is evaluated against the current pat and mode.
- Match latency: out_match is high for exactly the cycle following the completing accept. It is 0 on every other cycle, including non-accept cycles.
- Overlap mode (mode=0): fill is unaffected by a match.
- Non-overlap mode (mode=1): a match forces fill <= 0, so the next match needs WIDTH fresh accepted bits.
- out_cnt: increments by 1 on each match; saturates at 2^CNT_W-1 and never wraps.
- out_rise: the tool registers prev <= in on each accept. out_rise is high the cycle after an accept with in=1 and prev=0. The first accept after reset counts prev as 0.
- out_dly: DLY-stage shift of in every cycle, independent of in_vld. out_dly(t+DLY) = in(t).
- in_vld=0: sr, fill, prev and out_cnt hold; out_match and out_rise go to 0.
- pat or mode changes: take effect on the next accept; no flush.
- Reset mid-stream: partial pattern discarded (fill=0).

Optional Feature:
SEQ_BLK_STICKY_EN
- Defined: adds port clr (in, 1) and port out_sticky (out, 1), reset 0.
  - out_sticky sets on any cycle where the match condition holds, visible with out_match.
  - out_sticky clears on a clr edge.
  - Simultaneous match and clr: set wins.
- Undefined: both ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_blk_pkg: constants MODE_OVERLAP=1'b0 and MODE_NONOVL=1'b1; default WIDTH/CNT_W/DLY localparams.
- Sub-module seq_blk_dline (parameter DLY, ports clk/rst/d/q): the delay line, instantiated once.
- The rest is flat in seq_blk_det.

Test Plan:
1. WIDTH=4, pat=4'b1011, mode=0, accept stream 1,0,1,1,0,1,1 → out_match pulses after the 4th and 7th bits; out_cnt=2.
2. Same stream, mode=1 → single pulse after the 4th bit; out_cnt=1.
3. CNT_W=2, pat=4'b1111, mode=0, ten consecutive 1s → 7 pulses; out_cnt sequence 1,2,3,3,3,3,3.
4. Stream 1,0,1 accepted, then rst for 1 cycle, then 1 accepted → no match; out_cnt=0; all outputs 0 the cycle after rst.
5. DLY=3, single-cycle in=1 pulse at cycle 10, in_vld=0 throughout → out_dly high in cycle 13 only; out_match, out_rise and out_cnt stay 0.
6. Accepts 0,1 with in_vld=0 cycles (in toggling) inserted between them → out_rise pulses once, after the second accept. With SEQ_BLK_STICKY_EN: match and clr on the same edge → out_sticky=1; a later clr alone → out_sticky=0.
